// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and instruction memory (slave).
interface instruction_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC + fetch stage: one outstanding imem read, registered output with a one-entry skid.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst,
    instruction_fetch_unit_if.master        imem,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_pc,
    input  logic                            stall,
    output logic                            if_valid,
    output logic [31:0]                     if_instruction,
    output logic [31:0]                     if_pc,
    output logic [31:0]                     if_pc_plus4,
    output logic                            if_fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_instr_reg, out_instr_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic [31:0] out_pc_plus4_reg, out_pc_plus4_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;

    logic        fault_reg;
    logic [31:0] redirect_target;
    logic        consume;
    logic        req_fire;

`ifdef IF_MISALIGN_TRAP_EN
    logic fault_next;

    assign redirect_target = redirect_pc;
    assign fault_next      = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign fault_reg       = 1'b0;
`endif

    // A pending redirect retracts the request so a stale address is never accepted.
    assign imem.imem_req_valid = (state_reg == FETCH) && !skid_valid_reg &&
                                 !redirect_valid && !fault_reg;
    assign imem.imem_req_addr  = pc_reg;

    assign consume  = out_valid_reg && !stall;
    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        out_valid_next    = out_valid_reg;
        out_instr_next    = out_instr_reg;
        out_pc_next       = out_pc_reg;
        out_pc_plus4_next = out_pc_plus4_reg;
        skid_valid_next   = skid_valid_reg;
        skid_instr_next   = skid_instr_reg;
        skid_pc_next      = skid_pc_reg;

        if (redirect_valid) begin
            pc_next         = redirect_target;
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
            // Any fetch still in flight must have its response swallowed in DRAIN.
            case (state_reg)
                FETCH:   state_next = req_fire ? DRAIN : FETCH;
                WAIT:    state_next = imem.imem_resp_valid ? FETCH : DRAIN;
                DRAIN:   state_next = imem.imem_resp_valid ? FETCH : DRAIN;
                default: state_next = FETCH;
            endcase
        end else begin
            case (state_reg)
                FETCH: begin
                    if (req_fire) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_resp_valid) begin
                        state_next = FETCH;
                        pc_next    = pc_reg + 32'd4;
                    end
                end
                DRAIN: begin
                    if (imem.imem_resp_valid) begin
                        state_next = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase

            // Requests only issue with the skid empty, so a response never meets a full skid.
            if ((state_reg == WAIT) && imem.imem_resp_valid) begin
                if (!out_valid_reg || consume) begin
                    out_valid_next    = 1'b1;
                    out_instr_next    = imem.imem_resp_data;
                    out_pc_next       = pc_reg;
                    out_pc_plus4_next = pc_reg + 32'd4;
                end else begin
                    skid_valid_next = 1'b1;
                    skid_instr_next = imem.imem_resp_data;
                    skid_pc_next    = pc_reg;
                end
            end else if (consume) begin
                out_valid_next = skid_valid_reg;
                if (skid_valid_reg) begin
                    out_instr_next    = skid_instr_reg;
                    out_pc_next       = skid_pc_reg;
                    out_pc_plus4_next = skid_pc_reg + 32'd4;
                    skid_valid_next   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= FETCH;
            pc_reg           <= RESET_PC;
            out_valid_reg    <= 1'b0;
            out_instr_reg    <= 32'h0;
            out_pc_reg       <= 32'h0;
            out_pc_plus4_reg <= 32'h0;
            skid_valid_reg   <= 1'b0;
            skid_instr_reg   <= 32'h0;
            skid_pc_reg      <= 32'h0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            out_valid_reg    <= out_valid_next;
            out_instr_reg    <= out_instr_next;
            out_pc_reg       <= out_pc_next;
            out_pc_plus4_reg <= out_pc_plus4_next;
            skid_valid_reg   <= skid_valid_next;
            skid_instr_reg   <= skid_instr_next;
            skid_pc_reg      <= skid_pc_next;
        end
    end

    assign if_valid       = out_valid_reg;
    assign if_instruction = out_instr_reg;
    assign if_pc          = out_pc_reg;
    assign if_pc_plus4    = out_pc_plus4_reg;
    assign if_fault       = fault_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory returns data = addr + 0xA000_0000.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_fault;

    int          n_cmp = 0;
    int          n_err = 0;

    int          mem_lat = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          wait_cnt = 0;
    logic [31:0] last_acc_addr = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    instruction_fetch_unit_if imem_bus ();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_fault       (if_fault)
    );

    // Memory responder: decides acceptance at the negedge before the accepting posedge.
    initial begin
        imem_bus.imem_req_ready  = 1'b1;
        imem_bus.imem_resp_valid = 1'b0;
        imem_bus.imem_resp_data  = 32'h0;
    end

    always @(negedge clk) begin
        imem_bus.imem_resp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (wait_cnt == 0) begin
                    imem_bus.imem_resp_valid = 1'b1;
                    imem_bus.imem_resp_data  = pend_addr + 32'hA000_0000;
                    pend = 1'b0;
                end else begin
                    wait_cnt = wait_cnt - 1;
                end
            end
            if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
                pend          = 1'b1;
                pend_addr     = imem_bus.imem_req_addr;
                wait_cnt      = mem_lat - 1;
                last_acc_addr = imem_bus.imem_req_addr;
                $display("[%0t] imem request accepted addr=%h", $time, imem_bus.imem_req_addr);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && if_valid && !stall)
            $display("[%0t] decode takes pc=%h instr=%h", $time, if_pc, if_instruction);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        mem_lat        = 1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
        chk("rst_if_instr", if_instruction, 32'h0);
        chk("rst_if_fault", if_fault, 0);
        chk("rst_req_valid", imem_bus.imem_req_valid, 1);
        chk("rst_req_addr", imem_bus.imem_req_addr, 32'h0);

        // 1: streaming, one instruction every other cycle
        tick();
        chk("t1_wait_req_off", imem_bus.imem_req_valid, 0);
        chk("t1_wait_if_valid", if_valid, 0);
        chk("t1_first_addr", last_acc_addr, 32'h0);
        tick();
        chk("t1_i0_valid", if_valid, 1);
        chk("t1_i0_pc", if_pc, 32'h0);
        chk("t1_i0_pc4", if_pc_plus4, 32'h4);
        chk("t1_i0_instr", if_instruction, 32'hA000_0000);
        chk("t1_req_addr4", imem_bus.imem_req_addr, 32'h4);
        tick();
        chk("t1_gap0", if_valid, 0);
        tick();
        chk("t1_i1_valid", if_valid, 1);
        chk("t1_i1_pc", if_pc, 32'h4);
        chk("t1_i1_pc4", if_pc_plus4, 32'h8);
        chk("t1_i1_instr", if_instruction, 32'hA000_0004);
        tick();
        chk("t1_gap1", if_valid, 0);
        tick();
        chk("t1_i2_pc", if_pc, 32'h8);
        chk("t1_i2_pc4", if_pc_plus4, 32'hC);

        // 2: stall fills skid, then ordered drain
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        tick();
        chk("t2_hold_pc", if_pc, 32'h0);
        chk("t2_acc4", last_acc_addr, 32'h4);
        tick();
        chk("t2_skidfull_noreq", imem_bus.imem_req_valid, 0);
        tick();
        tick();
        tick();
        chk("t2_hold_valid", if_valid, 1);
        chk("t2_hold_pc_end", if_pc, 32'h0);
        chk("t2_hold_instr", if_instruction, 32'hA000_0000);
        chk("t2_still_noreq", imem_bus.imem_req_valid, 0);
        chk("t2_no_new_acc", last_acc_addr, 32'h4);
        stall = 1'b0;
        tick();
        chk("t2_skid_pc", if_pc, 32'h4);
        chk("t2_skid_pc4", if_pc_plus4, 32'h8);
        chk("t2_skid_instr", if_instruction, 32'hA000_0004);
        chk("t2_req_resume", imem_bus.imem_req_valid, 1);
        chk("t2_req_addr8", imem_bus.imem_req_addr, 32'h8);
        tick();
        chk("t2_gap", if_valid, 0);
        tick();
        chk("t2_i2_pc", if_pc, 32'h8);
        chk("t2_i2_instr", if_instruction, 32'hA000_0008);

        // 3: redirect while waiting; late response discarded
        do_reset();
        tick();
        tick();
        tick();
        tick();
        mem_lat = 2;
        tick();
        chk("t3_acc8", last_acc_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3_flush_valid", if_valid, 0);
        chk("t3_drain_noreq", imem_bus.imem_req_valid, 0);
        mem_lat = 1;
        tick();
        chk("t3_discard_valid", if_valid, 0);
        chk("t3_req_valid", imem_bus.imem_req_valid, 1);
        chk("t3_req_addr", imem_bus.imem_req_addr, 32'h100);
        tick();
        chk("t3_no_dup", if_valid, 0);
        chk("t3_acc100", last_acc_addr, 32'h100);
        tick();
        chk("t3_new_valid", if_valid, 1);
        chk("t3_new_pc", if_pc, 32'h100);
        chk("t3_new_instr", if_instruction, 32'hA000_0100);

        // 4: redirect coincident with response
        do_reset();
        repeat (7) tick();
        chk("t4_accC", last_acc_addr, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_dropC_valid", if_valid, 0);
        chk("t4_req_addr", imem_bus.imem_req_addr, 32'h200);
        tick();
        chk("t4_acc200", last_acc_addr, 32'h200);
        chk("t4_still_empty", if_valid, 0);
        tick();
        chk("t4_new_pc", if_pc, 32'h200);
        chk("t4_new_instr", if_instruction, 32'hA000_0200);

        // 5: wrap at top of address space, redirect in FETCH retracts request
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk("t5_retract", imem_bus.imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_req_addr", imem_bus.imem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_acc_top", last_acc_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_pc4_wrap", if_pc_plus4, 32'h0);
        chk("t5_instr", if_instruction, 32'h9FFF_FFFC);
        chk("t5_next_addr", imem_bus.imem_req_addr, 32'h0);
        tick();
        chk("t5_acc0", last_acc_addr, 32'h0);

        // 6: misaligned redirect
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
`ifdef IF_MISALIGN_TRAP_EN
        chk("t6_fault_set", if_fault, 1);
        chk("t6_valid_off", if_valid, 0);
        chk("t6_noreq", imem_bus.imem_req_valid, 0);
        tick();
        tick();
        tick();
        chk("t6_fault_hold", if_fault, 1);
        chk("t6_noreq_hold", imem_bus.imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t6_fault_clear", if_fault, 0);
        chk("t6_req_valid", imem_bus.imem_req_valid, 1);
        chk("t6_req_addr", imem_bus.imem_req_addr, 32'h300);
        tick();
        chk("t6_acc300", last_acc_addr, 32'h300);
`else
        chk("t6_fault_zero", if_fault, 0);
        chk("t6_req_valid", imem_bus.imem_req_valid, 1);
        chk("t6_req_addr", imem_bus.imem_req_addr, 32'h100);
        tick();
        chk("t6_acc100", last_acc_addr, 32'h100);
        tick();
        chk("t6_pc", if_pc, 32'h100);
        chk("t6_fault_still0", if_fault, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
